// File: rtl/sample_rate_sequencer.sv
// sample_rate_sequencer: maps host rate codes to DCM M/D values and sequences reprogram, lock and settle
module sample_rate_sequencer #(
  parameter int DEFAULT_CODE   = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SETTLE_CYCLES  = 1024
) (
  input  logic       ti_clk,
  input  logic       reset_n,
  input  logic [4:0] rate_code,
  input  logic       rate_req,
  input  logic       prog_done,
  input  logic       locked,
  output logic [8:0] M,
  output logic [8:0] D,
  output logic       DCM_prog_trigger,
  output logic       busy,
  output logic       acq_hold,
  output logic       rate_ok,
  output logic [1:0] err,
  output logic [4:0] current_code
);
  typedef enum logic [2:0] {IDLE, LOAD, TRIG, WAIT_DROP, WAIT_DONE, WAIT_LOCK, SETTLE} state_t;
  localparam int CMAX = TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  function automatic logic [17:0] rate_md(input logic [4:0] c);
    case (c)
      5'd0:  rate_md = {9'd7,   9'd125};
      5'd1:  rate_md = {9'd7,   9'd100};
      5'd2:  rate_md = {9'd21,  9'd250};
      5'd3:  rate_md = {9'd14,  9'd125};
      5'd4:  rate_md = {9'd35,  9'd250};
      5'd5:  rate_md = {9'd21,  9'd125};
      5'd6:  rate_md = {9'd14,  9'd75};
      5'd7:  rate_md = {9'd28,  9'd125};
      5'd8:  rate_md = {9'd7,   9'd25};
      5'd9:  rate_md = {9'd7,   9'd20};
      5'd10: rate_md = {9'd112, 9'd250};
      5'd11: rate_md = {9'd14,  9'd25};
      5'd12: rate_md = {9'd7,   9'd10};
      5'd13: rate_md = {9'd21,  9'd25};
      5'd14: rate_md = {9'd28,  9'd25};
      5'd15: rate_md = {9'd35,  9'd25};
      5'd16: rate_md = {9'd42,  9'd25};
      5'd17: rate_md = {9'd28,  9'd15};
      5'd18: rate_md = {9'd56,  9'd25};
      5'd19: rate_md = {9'd14,  9'd5};
      default: rate_md = '0;
    endcase
  endfunction

  localparam logic [17:0] DEF_MD = rate_md(5'(DEFAULT_CODE));

  state_t state, next;
  logic [1:0] pd_q, lk_q;
  logic [CW-1:0] cnt;
  logic prog_done_s, locked_s, prog_ok, accept, wait_st, tmo;

  assign prog_done_s = pd_q[1];
  assign locked_s = lk_q[1];
  assign accept = state == IDLE && rate_req && rate_code < 5'd20;
  assign wait_st = state inside {WAIT_DROP, WAIT_DONE, WAIT_LOCK};
  assign tmo = wait_st && cnt == TMO_LAST;
  assign busy = state != IDLE;
  assign acq_hold = busy;
  assign DCM_prog_trigger = state == TRIG;

  // bring the generator's asynchronous status into ti_clk
  always_ff @(posedge ti_clk or negedge reset_n)
    if (!reset_n) {pd_q, lk_q} <= '0;
    else {pd_q, lk_q} <= {pd_q[0], prog_done, lk_q[0], locked};

  // state register
  always_ff @(posedge ti_clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;

  // sequence: load, single trigger, then follow PROGDONE/LOCKED with a shared timeout
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = accept ? LOAD : IDLE;
      LOAD:      next = TRIG;
      TRIG:      next = WAIT_DROP;
      WAIT_DROP: next = !prog_done_s ? WAIT_DONE : tmo ? IDLE : WAIT_DROP;
      WAIT_DONE: next = prog_done_s ? WAIT_LOCK : tmo ? IDLE : WAIT_DONE;
      WAIT_LOCK: next = locked_s ? SETTLE : tmo ? IDLE : WAIT_LOCK;
      SETTLE:    next = cnt == SETTLE_LAST ? IDLE : SETTLE;
      default:   next = IDLE;
    endcase
  end

  // one counter: timeout across all wait states, restarted for the settle interval
  always_ff @(posedge ti_clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (state == TRIG || (state == WAIT_LOCK && locked_s)) cnt <= '0;
    else if (wait_st || state == SETTLE) cnt <= cnt + CW'(1);

  // M/D are loaded on acceptance so they are stable through LOAD before the trigger
  always_ff @(posedge ti_clk or negedge reset_n)
    if (!reset_n) begin
      {M, D} <= DEF_MD;
      current_code <= 5'(DEFAULT_CODE);
      err <= '0;
      rate_ok <= 1'b0;
      prog_ok <= 1'b1;
    end else if (accept) begin
      {M, D} <= rate_md(rate_code);
      current_code <= rate_code;
      err <= '0;
      rate_ok <= 1'b0;
      prog_ok <= 1'b0;
    end else if (state == IDLE) begin
      err <= rate_req ? 2'd1 : (rate_ok && !locked_s) ? 2'd3 : err;
      rate_ok <= rate_req ? rate_ok : prog_ok && locked_s;
    end else if (tmo && next == IDLE) begin
      err <= state == WAIT_LOCK ? 2'd3 : 2'd2;
    end else if (state == SETTLE && next == IDLE) begin
      rate_ok <= 1'b1;
      prog_ok <= 1'b1;
    end
endmodule
